// File: rtl/uart_fifo_pkg.sv
// Shared constants and types for the UART FIFO: default geometry, pointer width helper
// and the error-flag struct that the UART status register also uses.
package uart_fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 16;

    // One extra bit beyond the address gives the wrap bit for full/empty decode.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// DEPTH x DATA_W storage with one synchronous write port and one read port.
// Read port is registered by default and combinational when UART_FIFO_FWFT_EN is defined.
module uart_fifo_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

`ifdef UART_FIFO_FWFT_EN
    logic unused_ok;
    assign unused_ok = rst_i ^ re_i;
    assign rdata_o   = mem_q[raddr_i];
`else
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/uart_fifo_sync.sv
// Parametrised synchronous FIFO for the UART TX/RX paths with level, watermarks, sticky
// errors and flush. Define UART_FIFO_FWFT_EN for first-word-fall-through reads.
module uart_fifo_sync
    import uart_fifo_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   wr_en,
    input  logic [DATA_W-1:0]      wr_data,
    input  logic                   rd_en,
    output logic [DATA_W-1:0]      rd_data,
    output logic                   rd_valid,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;
    localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
    localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    fifo_err_t     err_q, err_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_acc, wr_acc;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

    // A read frees the slot in the same cycle, so a full FIFO still accepts a paired write.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        err_d      = err_q;
        rd_valid_d = 1'b0;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            err_d    = '0;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_acc) rd_ptr_d = rd_ptr_q + PW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   level_d = level_q + PW'(1);
                2'b01:   level_d = level_q - PW'(1);
                default: level_d = level_q;
            endcase
            err_d.overflow  = err_q.overflow  | (wr_en && !wr_acc);
            err_d.underflow = err_q.underflow | (rd_en && empty);
            rd_valid_d      = rd_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            err_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    uart_fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk     (clk),
        .rst_i   (rst),
        .we_i    (wr_acc && !clr && !rst),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i (wr_data),
        .re_i    (rd_acc && !clr && !rst),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_data)
    );

`ifdef UART_FIFO_FWFT_EN
    logic unused_rv;
    assign unused_rv = rd_valid_q;
    assign rd_valid  = !empty;
`else
    assign rd_valid  = rd_valid_q;
`endif

    assign level        = level_q;
    assign almost_full  = (level_q >= AF_L);
    assign almost_empty = (level_q <= AE_L);
    assign overflow     = err_q.overflow;
    assign underflow    = err_q.underflow;

endmodule
